// File: rtl/servisia_pkg.sv
// Shared types and constants for the servisia byte-wide memory bridge.
package servisia_pkg;

  localparam int MEM_AW_DEF = 21;
  localparam int NUM_BYTES  = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_ACK    = 2'd3
  } state_e;

  // Request fields latched at acceptance; the address is kept separately
  // because its width follows MEM_AW.
  typedef struct packed {
    logic        we;
    logic [3:0]  sel;
    logic [31:0] dat;
  } req_t;

endpackage

// File: rtl/servisia_mem_bridge_if.sv
// CPU-side Wishbone-style bus and byte-wide memory-side bus of the bridge.
interface servisia_wb_if;
  logic [31:0] adr;
  logic [31:0] dat;
  logic [3:0]  sel;
  logic        we;
  logic        cyc;
  logic [31:0] rdt;
  logic        ack;

  modport master (output adr, dat, sel, we, cyc, input rdt, ack);
  modport slave  (input adr, dat, sel, we, cyc, output rdt, ack);
endinterface

interface servisia_mem_if #(parameter int MEM_AW = 21);
  logic              read;
  logic              write;
  logic [MEM_AW-1:0] addr;
  logic [7:0]        wdata;
  logic [7:0]        rdata;

  modport master (output read, write, addr, wdata, input rdata);
  modport slave  (input read, write, addr, wdata, output rdata);
endinterface

// File: rtl/servisia_mem_bridge.sv
// Splits a 32-bit bus request into four byte strobes and reassembles reads.
// Optional: SERVISIA_MEM_BRIDGE_ROM_PROTECT_EN blocks write strobes to flash.
module servisia_mem_bridge
  import servisia_pkg::*;
#(
    parameter int MEM_AW = MEM_AW_DEF
) (
    input  logic            clk_i,
    input  logic            rst_i,
    servisia_wb_if.slave    wb,
    servisia_mem_if.master  mem
);

    state_e              state_q, state_d;
    logic [1:0]          cnt_q, cnt_d;
    req_t                req_q, req_d;
    logic [MEM_AW-3:0]   adr_q, adr_d;
    logic [31:0]         rdata_q, rdata_d;
    logic [31:0]         rdt_q, rdt_d;
    logic                ack_q, ack_d;
    logic                read_q, read_d;
    logic                write_q, write_d;
    logic [MEM_AW-1:0]   addr_q, addr_d;
    logic [7:0]          wdata_q, wdata_d;
    logic                issue;
    logic                wr_allowed;
    logic                unused_adr;

    assign unused_adr = ^{wb.adr[31:MEM_AW], wb.adr[1:0]};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_d      = req_q;
        adr_d      = adr_q;
        rdata_d    = rdata_q;
        rdt_d      = rdt_q;
        ack_d      = 1'b0;
        read_d     = 1'b0;
        write_d    = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        issue      = 1'b0;
        wr_allowed = 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (wb.cyc) begin
                    req_d   = '{we: wb.we, sel: wb.sel, dat: wb.dat};
                    adr_d   = wb.adr[MEM_AW-1:2];
                    cnt_d   = 2'd0;
                    state_d = ST_ACCESS;
                    issue   = 1'b1;
                end
            end
            ST_ACCESS: begin
                if (!wb.cyc) begin
                    state_d = ST_IDLE;
                    cnt_d   = 2'd0;
                end else begin
                    // Memory data lags its strobe by one cycle.
                    if (!req_q.we && cnt_q != 2'd0)
                        rdata_d[{cnt_q - 2'd1, 3'b000} +: 8] = mem.rdata;
                    if (cnt_q == 2'(NUM_BYTES - 1)) begin
                        cnt_d   = 2'd0;
                        state_d = req_q.we ? ST_ACK : ST_DRAIN;
                        ack_d   = req_q.we;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                        issue = 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (!wb.cyc) begin
                    state_d = ST_IDLE;
                end else begin
                    rdata_d[31:24] = mem.rdata;
                    rdt_d          = {mem.rdata, rdata_q[23:0]};
                    ack_d          = 1'b1;
                    state_d        = ST_ACK;
                end
            end
            ST_ACK: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

`ifdef SERVISIA_MEM_BRIDGE_ROM_PROTECT_EN
        wr_allowed = adr_d[MEM_AW-3];
`else
        wr_allowed = 1'b1;
`endif

        if (issue) begin
            addr_d  = {adr_d, cnt_d};
            read_d  = !req_d.we;
            write_d = req_d.we && req_d.sel[cnt_d] && wr_allowed;
            wdata_d = req_d.dat[{cnt_d, 3'b000} +: 8];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= 2'd0;
            req_q   <= '0;
            adr_q   <= '0;
            rdata_q <= '0;
            rdt_q   <= '0;
            ack_q   <= 1'b0;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            adr_q   <= adr_d;
            rdata_q <= rdata_d;
            rdt_q   <= rdt_d;
            ack_q   <= ack_d;
            read_q  <= read_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign wb.rdt    = rdt_q;
    assign wb.ack    = ack_q;
    assign mem.read  = read_q;
    assign mem.write = write_q;
    assign mem.addr  = addr_q;
    assign mem.wdata = wdata_q;

endmodule
